grad_seq_ctrl: RTL and testbench

Sequencer for the gradient BRAM readout path. It drives the BRAM read offset and data-enable strobe at a programmed sample interval, steps through a programmed offset window, and waits for the BRAM's valid response. It holds off while the downstream serialiser is busy and reports completion, underrun and timeout. It sits between the AXI-configured control registers and the gradient BRAM's offset/enable inputs.

---
 rtl/grad_pkg.sv | 18 +
 rtl/grad_interval_timer.sv | 37 +++
 rtl/grad_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_grad_seq_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_pkg.sv
// Shared types and constants for the gradient BRAM readout sequencer.
// State encoding, sticky error bit positions and the default interval floor.
package grad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_WAIT_TIMER = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_TIMEOUT  = 1;

    localparam int DEFAULT_MIN_INTERVAL = 4;

endpackage

// File: rtl/grad_interval_timer.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
// expired_o is high while the count is zero.
module grad_interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/grad_seq_ctrl.sv
// Gradient BRAM readout sequencer: strobes data_enb_o once per latched interval
// across an offset window, stalls on serial_busy_i, flags underrun/valid timeout.
module grad_seq_ctrl
    import grad_pkg::*;
#(
    parameter int OFFSET_WIDTH   = 16,
    parameter int INTERVAL_WIDTH = 32,
    parameter int MIN_INTERVAL   = DEFAULT_MIN_INTERVAL
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [OFFSET_WIDTH-1:0]   start_offset_i,
    input  logic [OFFSET_WIDTH-1:0]   end_offset_i,
    input  logic [INTERVAL_WIDTH-1:0] interval_i,
    input  logic                      serial_busy_i,
    input  logic                      valid_i,
    output logic [OFFSET_WIDTH-1:0]   offset_o,
    output logic                      data_enb_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [1:0]                err_o,
    output logic [OFFSET_WIDTH-1:0]   sample_cnt_o
);

    localparam logic [INTERVAL_WIDTH-1:0] MIN_IVL = INTERVAL_WIDTH'(MIN_INTERVAL);

    state_t                    state_q, state_d;
    logic [OFFSET_WIDTH-1:0]   offset_q, offset_d;
    logic [OFFSET_WIDTH-1:0]   end_q, end_d;
    logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
    logic [1:0]                err_q, err_d;
    logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;

    logic                      tmr_load;
    logic [INTERVAL_WIDTH-1:0] tmr_load_val;
    logic [INTERVAL_WIDTH-1:0] tmr_cnt;
    logic                      tmr_expired;
    logic                      tmr_last;

    grad_interval_timer #(
        .WIDTH (INTERVAL_WIDTH)
    ) u_timer (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .cnt_o      (tmr_cnt),
        .expired_o  (tmr_expired)
    );

    // Timer reaches zero at the next edge, i.e. the next strobe is due next cycle.
    assign tmr_last = tmr_expired || (tmr_cnt == INTERVAL_WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        end_d        = end_q;
        interval_d   = interval_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        data_enb_o   = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    end_d        = end_offset_i;
                    interval_d   = (interval_i < MIN_IVL) ? MIN_IVL : interval_i;
                    offset_d     = start_offset_i;
                    err_d        = '0;
                    cnt_d        = '0;
                    // First strobe is due immediately.
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (serial_busy_i) begin
                    if (tmr_expired) begin
                        err_d[ERR_UNDERRUN] = 1'b1;
                    end
                end else begin
                    data_enb_o   = 1'b1;
                    cnt_d        = cnt_q + OFFSET_WIDTH'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = interval_q - INTERVAL_WIDTH'(1);
                    state_d      = ST_WAIT_VALID;
                end
            end
            ST_WAIT_VALID: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (valid_i) begin
                    if (offset_q == end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        offset_d = offset_q + OFFSET_WIDTH'(1);
                        // A valid on the last wait cycle leaves no room for WAIT_TIMER.
                        state_d  = tmr_last ? ST_ISSUE : ST_WAIT_TIMER;
                    end
                end else if (tmr_last) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_DONE;
                end
            end
            ST_WAIT_TIMER: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_last) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                done_o  = !stop_i;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            offset_q   <= '0;
            end_q      <= '0;
            interval_q <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            end_q      <= end_d;
            interval_q <= interval_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign offset_o     = offset_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_grad_seq_ctrl.sv
// Self-checking bench for grad_seq_ctrl: directed scenarios plus randomized windows,
// checked against strobe timing/offset expectations derived from window arithmetic.
module tb_grad_seq_ctrl;

    localparam int OW = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [OW-1:0] start_offset_i = '0;
    logic [OW-1:0] end_offset_i = '0;
    logic [IW-1:0] interval_i = '0;
    logic          serial_busy_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [OW-1:0] offset_o;
    logic          data_enb_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    err_o;
    logic [OW-1:0] sample_cnt_o;

    grad_seq_ctrl #(
        .OFFSET_WIDTH   (OW),
        .INTERVAL_WIDTH (IW),
        .MIN_INTERVAL   (4)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .start_offset_i (start_offset_i),
        .end_offset_i   (end_offset_i),
        .interval_i     (interval_i),
        .serial_busy_i  (serial_busy_i),
        .valid_i        (valid_i),
        .offset_o       (offset_o),
        .data_enb_o     (data_enb_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .sample_cnt_o   (sample_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Cycle index, BRAM responder and strobe/done monitor.
    int          cyc = 0;
    int          due = -1;
    int          last_due = -1;
    bit          resp_on = 1'b0;
    int unsigned dlo = 1;
    int unsigned dhi = 1;
    int            strb_cyc[$];
    logic [OW-1:0] strb_off[$];
    int          done_cnt = 0;
    int          done_cyc = -1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        valid_i = resp_on && (cyc == due);
    end

    always @(negedge clk) begin
        if (data_enb_o) begin
            strb_cyc.push_back(cyc);
            strb_off.push_back(offset_o);
            if (resp_on) begin
                due      = cyc + int'($urandom_range(dhi, dlo));
                last_due = due;
            end
        end
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        strb_cyc.delete();
        strb_off.delete();
        done_cnt = 0;
        done_cyc = -1;
        due      = -1;
        last_due = -1;
    endtask

    // Pulse start; scyc is the cycle in which start_i is high. Inputs are scrambled
    // afterwards so any failure to latch shows up as wrong offsets or spacing.
    task automatic do_start(input logic [OW-1:0] s, input logic [OW-1:0] e,
                            input logic [IW-1:0] ivl, output int scyc);
        @(posedge clk);
        #1;
        start_offset_i = s;
        end_offset_i   = e;
        interval_i     = ivl;
        start_i        = 1'b1;
        scyc           = cyc;
        @(posedge clk);
        #1;
        start_i        = 1'b0;
        start_offset_i = OW'($urandom);
        end_offset_i   = OW'($urandom);
        interval_i     = $urandom;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strobes(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (strb_cyc.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (offset_o !== 16'h0) begin n_bad++; $display("FAIL reset_offset: got %h want 0", offset_o); end
        n_vec++; if (data_enb_o !== 1'b0) begin n_bad++; $display("FAIL reset_enb: got %b want 0", data_enb_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_vec++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_vec++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", err_o); end
        n_vec++; if (sample_cnt_o !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", sample_cnt_o); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int sc;
        bit ok;
        logic [OW-1:0] exp_off;
        clear_mon();
        resp_on = 1'b1; dlo = 2; dhi = 2;
        do_start(16'h0010, 16'h0013, 32'd10, sc);
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL basic_idle: busy_o still %b, want 0", busy_o); end
        n_vec++; if (strb_cyc.size() !== 4) begin n_bad++; $display("FAIL basic_nstrb: got %0d want 4", strb_cyc.size()); end
        for (int i = 0; i < strb_cyc.size() && i < 4; i++) begin
            exp_off = 16'h0010 + OW'(i);
            n_vec++; if (strb_off[i] !== exp_off) begin n_bad++; $display("FAIL basic_off[%0d]: got %h want %h", i, strb_off[i], exp_off); end
            n_vec++;
            if (i == 0) begin
                if (strb_cyc[0] !== sc + 1) begin n_bad++; $display("FAIL basic_first: got cycle %0d want %0d", strb_cyc[0], sc + 1); end
            end else if (strb_cyc[i] - strb_cyc[i-1] !== 10) begin
                n_bad++; $display("FAIL basic_gap[%0d]: got %0d want 10", i, strb_cyc[i] - strb_cyc[i-1]);
            end
        end
        n_vec++; if (sample_cnt_o !== 16'd4) begin n_bad++; $display("FAIL basic_cnt: got %0d want 4", sample_cnt_o); end
        n_vec++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL basic_err: got %b want 00", err_o); end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_vec++; if (done_cyc !== last_due + 1) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, last_due + 1); end
    endtask

    task automatic test_wrap();
        int sc;
        bit ok;
        logic [OW-1:0] exp_off;
        clear_mon();
        resp_on = 1'b1; dlo = 1; dhi = 3;
        do_start(16'hFFFE, 16'h0001, 32'd4, sc);
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL wrap_idle: busy_o still %b, want 0", busy_o); end
        n_vec++; if (strb_cyc.size() !== 4) begin n_bad++; $display("FAIL wrap_nstrb: got %0d want 4", strb_cyc.size()); end
        for (int i = 0; i < strb_cyc.size() && i < 4; i++) begin
            exp_off = 16'hFFFE + OW'(i);
            n_vec++; if (strb_off[i] !== exp_off) begin n_bad++; $display("FAIL wrap_off[%0d]: got %h want %h", i, strb_off[i], exp_off); end
            if (i > 0) begin
                n_vec++; if (strb_cyc[i] - strb_cyc[i-1] !== 4) begin n_bad++; $display("FAIL wrap_gap[%0d]: got %0d want 4", i, strb_cyc[i] - strb_cyc[i-1]); end
            end
        end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
        n_vec++; if (sample_cnt_o !== 16'd4) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 4", sample_cnt_o); end
    endtask

    task automatic test_serial_busy();
        int sc;
        int drop;
        bit ok;
        clear_mon();
        resp_on = 1'b1; dlo = 2; dhi = 2;
        do_start(16'h0000, 16'h0002, 32'd8, sc);
        wait_strobes(1, 50, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sbusy_first: got %0d strobes want 1", strb_cyc.size()); end
        @(posedge clk);
        #1 serial_busy_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 serial_busy_i = 1'b0;
        drop = cyc;
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sbusy_idle: busy_o still %b, want 0", busy_o); end
        n_vec++; if (strb_cyc.size() !== 3) begin n_bad++; $display("FAIL sbusy_nstrb: got %0d want 3", strb_cyc.size()); end
        if (strb_cyc.size() == 3) begin
            n_vec++; if (strb_cyc[1] !== drop) begin n_bad++; $display("FAIL sbusy_second: got cycle %0d want %0d", strb_cyc[1], drop); end
            n_vec++; if (strb_cyc[2] - strb_cyc[1] !== 8) begin n_bad++; $display("FAIL sbusy_gap: got %0d want 8", strb_cyc[2] - strb_cyc[1]); end
            n_vec++; if (strb_off[2] !== 16'h0002) begin n_bad++; $display("FAIL sbusy_off: got %h want 0002", strb_off[2]); end
        end
        n_vec++; if (err_o !== 2'b01) begin n_bad++; $display("FAIL sbusy_err: got %b want 01", err_o); end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL sbusy_done: got %0d want 1", done_cnt); end
        n_vec++; if (sample_cnt_o !== 16'd3) begin n_bad++; $display("FAIL sbusy_cnt: got %0d want 3", sample_cnt_o); end
    endtask

    task automatic test_timeout();
        int sc;
        bit ok;
        clear_mon();
        resp_on = 1'b0;
        do_start(16'h0005, 16'h0009, 32'd6, sc);
        wait_idle(100, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL tout_idle: busy_o still %b, want 0", busy_o); end
        n_vec++; if (strb_cyc.size() !== 1) begin n_bad++; $display("FAIL tout_nstrb: got %0d want 1", strb_cyc.size()); end
        n_vec++; if (done_cyc !== sc + 7) begin n_bad++; $display("FAIL tout_done_cyc: got %0d want %0d", done_cyc, sc + 7); end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL tout_done: got %0d want 1", done_cnt); end
        n_vec++; if (err_o !== 2'b10) begin n_bad++; $display("FAIL tout_err: got %b want 10", err_o); end
        n_vec++; if (sample_cnt_o !== 16'd1) begin n_bad++; $display("FAIL tout_cnt: got %0d want 1", sample_cnt_o); end
    endtask

    task automatic test_stop_restart();
        int sc;
        int rc;
        bit ok;
        clear_mon();
        resp_on = 1'b1; dlo = 2; dhi = 3;
        do_start(16'h0100, 16'h01FF, 32'd1, sc);
        wait_strobes(1, 50, ok);
        @(posedge clk);
        #1;
        start_offset_i = 16'h0055;
        interval_i     = 32'd20;
        start_i        = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_strobes(2, 50, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL stop_two: got %0d strobes want 2", strb_cyc.size()); end
        if (strb_cyc.size() >= 2) begin
            n_vec++; if (strb_cyc[1] - strb_cyc[0] !== 4) begin n_bad++; $display("FAIL stop_clamp_gap: got %0d want 4", strb_cyc[1] - strb_cyc[0]); end
            n_vec++; if (strb_off[1] !== 16'h0101) begin n_bad++; $display("FAIL stop_latched_off: got %h want 0101", strb_off[1]); end
        end
        @(posedge clk);
        #1 stop_i = 1'b1;
        @(posedge clk);
        #1 stop_i = 1'b0;
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy_o); end
        n_vec++; if (offset_o !== 16'h0101) begin n_bad++; $display("FAIL stop_hold_off: got %h want 0101", offset_o); end
        n_vec++; if (sample_cnt_o !== 16'd2) begin n_bad++; $display("FAIL stop_hold_cnt: got %0d want 2", sample_cnt_o); end
        repeat (20) @(negedge clk);
        n_vec++; if (strb_cyc.size() !== 2) begin n_bad++; $display("FAIL stop_quiet: got %0d strobes want 2", strb_cyc.size()); end
        n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL stop_nodone: got %0d want 0", done_cnt); end
        n_vec++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL stop_err: got %b want 00", err_o); end

        // Start and stop together in IDLE: start wins.
        clear_mon();
        @(posedge clk);
        #1;
        start_offset_i = 16'h0007;
        end_offset_i   = 16'h0007;
        interval_i     = 32'd0;
        start_i        = 1'b1;
        stop_i         = 1'b1;
        rc             = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        wait_idle(100, ok);
        n_vec++; if (strb_cyc.size() !== 1) begin n_bad++; $display("FAIL restart_nstrb: got %0d want 1", strb_cyc.size()); end
        if (strb_cyc.size() >= 1) begin
            n_vec++; if (strb_cyc[0] !== rc + 1) begin n_bad++; $display("FAIL restart_cyc: got %0d want %0d", strb_cyc[0], rc + 1); end
            n_vec++; if (strb_off[0] !== 16'h0007) begin n_bad++; $display("FAIL restart_off: got %h want 0007", strb_off[0]); end
        end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
        n_vec++; if (sample_cnt_o !== 16'd1) begin n_bad++; $display("FAIL restart_cnt: got %0d want 1", sample_cnt_o); end
    endtask

    task automatic test_reset_mid_run();
        int sc;
        bit ok;
        clear_mon();
        resp_on = 1'b1; dlo = 2; dhi = 2;
        do_start(16'h0020, 16'h0040, 32'd10, sc);
        wait_strobes(1, 50, ok);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (offset_o !== 16'h0) begin n_bad++; $display("FAIL rstmid_off: got %h want 0", offset_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        n_vec++; if (sample_cnt_o !== 16'h0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", sample_cnt_o); end
        n_vec++; if (data_enb_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_enb: got %b want 0", data_enb_o); end
        n_vec++; if ({done_o, err_o} !== 3'b000) begin n_bad++; $display("FAIL rstmid_done_err: got %b want 000", {done_o, err_o}); end
        clear_mon();
        resp_on = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (strb_cyc.size() !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d strobes want 0", strb_cyc.size()); end
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_random();
        int sc;
        bit ok;
        int len;
        int eff;
        logic [OW-1:0] s;
        logic [OW-1:0] e;
        logic [IW-1:0] ivl;
        logic [OW-1:0] exp_off;
        for (int r = 0; r < 8; r++) begin
            s   = OW'($urandom);
            len = int'($urandom_range(5, 1));
            e   = s + OW'(len - 1);
            ivl = IW'($urandom_range(9, 0));
            eff = (ivl < 4) ? 4 : int'(ivl);
            clear_mon();
            resp_on = 1'b1; dlo = 1; dhi = eff - 1;
            do_start(s, e, ivl, sc);
            wait_idle(len * eff + 50, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL rnd%0d_idle: busy_o still %b, want 0", r, busy_o); end
            n_vec++; if (strb_cyc.size() !== len) begin n_bad++; $display("FAIL rnd%0d_nstrb: got %0d want %0d", r, strb_cyc.size(), len); end
            for (int i = 0; i < strb_cyc.size() && i < len; i++) begin
                exp_off = s + OW'(i);
                n_vec++; if (strb_off[i] !== exp_off) begin n_bad++; $display("FAIL rnd%0d_off[%0d]: got %h want %h", r, i, strb_off[i], exp_off); end
                if (i > 0) begin
                    n_vec++; if (strb_cyc[i] - strb_cyc[i-1] !== eff) begin n_bad++; $display("FAIL rnd%0d_gap[%0d]: got %0d want %0d", r, i, strb_cyc[i] - strb_cyc[i-1], eff); end
                end
            end
            n_vec++; if (sample_cnt_o !== OW'(len)) begin n_bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", r, sample_cnt_o, len); end
            n_vec++; if (done_cnt !== 1 || done_cyc !== last_due + 1) begin
                n_bad++; $display("FAIL rnd%0d_done: got %0d pulses at %0d want 1 at %0d", r, done_cnt, done_cyc, last_due + 1);
            end
            n_vec++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL rnd%0d_err: got %b want 00", r, err_o); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_serial_busy();
        test_timeout();
        test_stop_restart();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
